// File: rtl/locked_register_reader_if.sv
// Read-request / response handshake bundle for locked_register_reader.
interface locked_register_reader_if #(
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic [1:0]        rd_addr;
  logic              rd_ready;
  logic              rd_busy;
  logic              rd_valid;
  logic [DATA_W-1:0] Data_out;
  logic              rd_err;

  modport master (
    output rd_req, rd_addr, rd_ready,
    input  rd_busy, rd_valid, Data_out, rd_err
  );

  modport slave (
    input  rd_req, rd_addr, rd_ready,
    output rd_busy, rd_valid, Data_out, rd_err
  );
endinterface

// File: rtl/locked_register_reader.sv
// Reads one of four register entries through a per-entry sticky read lock.
// Locked entries return zero with rd_err unless the requester is trusted and
// in debug mode; denials are counted in a saturating counter.
module locked_register_reader #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                  Clk,
  input  logic                  resetn,
  locked_register_reader_if.slave rd_bus,
  input  logic [4*DATA_W-1:0]   Reg_data,
  input  logic                  Lock,
  input  logic [1:0]            lock_addr,
  input  logic                  trusted,
  input  logic                  debug_mode,
  output logic [3:0]            lock_status,
  output logic [CNT_W-1:0]      deny_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [3:0]        lock_q, lock_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] entry_sel;
  logic              allow;

  // Select the register entry addressed by the captured read address.
  always_comb begin
    entry_sel = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (addr_q == i[1:0]) begin
        entry_sel = Reg_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state, permission check, response and lock/counter updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    // The lock check below reads lock_q, so a same-cycle Lock never
    // affects the fetch in progress.
    lock_d  = lock_q | (Lock ? (4'b0001 << lock_addr) : 4'b0000);
    allow   = ~lock_q[addr_q] | (trusted & debug_mode);

    unique case (state_q)
      IDLE: begin
        if (rd_bus.rd_req) begin
          addr_d  = rd_bus.rd_addr;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (allow) begin
          data_d = entry_sel;
          err_d  = 1'b0;
        end else begin
          data_d = '0;
          err_d  = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rd_bus.rd_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      lock_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd_bus.rd_busy  = (state_q != IDLE);
  assign rd_bus.rd_valid = valid_q;
  assign rd_bus.Data_out = data_q;
  assign rd_bus.rd_err   = err_q;
  assign lock_status     = lock_q;
  assign deny_count      = cnt_q;

endmodule

// File: tb/tb_locked_register_reader.sv
// Self-checking bench for locked_register_reader: a transaction-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_locked_register_reader;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              Clk;
  logic              resetn;
  logic [4*DATA_W-1:0] Reg_data;
  logic              Lock;
  logic [1:0]        lock_addr;
  logic              trusted;
  logic              debug_mode;
  logic [3:0]        lock_status;
  logic [CNT_W-1:0]  deny_count;

  locked_register_reader_if #(.DATA_W(DATA_W)) bus ();

  locked_register_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .resetn     (resetn),
    .rd_bus     (bus),
    .Reg_data   (Reg_data),
    .Lock       (Lock),
    .lock_addr  (lock_addr),
    .trusted    (trusted),
    .debug_mode (debug_mode),
    .lock_status(lock_status),
    .deny_count (deny_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A read goes through: accepted -> one cycle of evaluation -> response
  // held until the consumer takes it. m_age counts cycles since acceptance
  // (0 = no read outstanding).
  bit        m_locked [4];
  int        m_denials;
  int        m_age;
  int        m_addr;
  bit [15:0] m_data;
  bit        m_err;

  always @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      foreach (m_locked[i]) m_locked[i] = 1'b0;
      m_denials = 0;
      m_age = 0;
      m_addr = 0;
      m_data = '0;
      m_err = 1'b0;
    end else begin
      if (m_age == 0) begin
        if (bus.rd_req) begin
          m_addr = bus.rd_addr;
          m_age = 1;
        end
      end else if (m_age == 1) begin
        if (!m_locked[m_addr] || (trusted && debug_mode)) begin
          m_data = Reg_data[m_addr*DATA_W +: DATA_W];
          m_err = 1'b0;
        end else begin
          m_data = '0;
          m_err = 1'b1;
          if (m_denials < CNT_MAX) m_denials++;
        end
        m_age = 2;
      end else begin
        if (bus.rd_ready) m_age = 0;
      end
      if (Lock) m_locked[lock_addr] = 1'b1;
    end
  end

  function automatic logic [3:0] m_lock_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_locked[i];
    return v;
  endfunction

  bit cmp_en = 1'b0;

  // Every-cycle comparison away from the active edge.
  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("cyc_busy",  32'(bus.rd_busy),  32'(m_age != 0));
      chk("cyc_valid", 32'(bus.rd_valid), 32'(m_age == 2));
      chk("cyc_data",  32'(bus.Data_out), 32'(m_data));
      chk("cyc_err",   32'(bus.rd_err),   32'(m_err));
      chk("cyc_lock",  32'(lock_status),  32'(m_lock_vec()));
      chk("cyc_deny",  32'(deny_count),   32'(m_denials));
    end
  end

  // ---------------- stimulus ----------------
  // Entered and left at ~2 time units after a rising edge.
  task automatic do_read(input logic [1:0] a, input logic t, input logic d,
                         input logic lock_in_fetch,
                         output logic [15:0] dat, output logic e);
    bus.rd_req = 1'b1;
    bus.rd_addr = a;
    trusted = t;
    debug_mode = d;
    @(posedge Clk);
    #2;
    bus.rd_req = 1'b0;
    chk("accept_busy", 32'(bus.rd_busy), 32'd1);
    if (lock_in_fetch) begin
      Lock = 1'b1;
      lock_addr = a;
    end
    @(posedge Clk);
    #1;
    chk("latency_valid", 32'(bus.rd_valid), 32'd1);
    dat = bus.Data_out;
    e = bus.rd_err;
    #1;
    Lock = 1'b0;
    if (bus.rd_ready) begin
      @(posedge Clk);
      #1;
      chk("done_idle", 32'(bus.rd_busy), 32'd0);
      chk("done_valid", 32'(bus.rd_valid), 32'd0);
      #1;
    end
  endtask

  logic [15:0] dat, held_dat;
  logic        e, held_e;

  initial begin
    resetn = 1'b0;
    bus.rd_req = 1'b0;
    bus.rd_addr = 2'd0;
    bus.rd_ready = 1'b1;
    Reg_data = {16'h3C3C, 16'hA5A5, 16'h1234, 16'hBEEF};
    Lock = 1'b0;
    lock_addr = 2'd0;
    trusted = 1'b0;
    debug_mode = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_busy",  32'(bus.rd_busy),  32'd0);
    chk("rst_data",  32'(bus.Data_out), 32'd0);
    chk("rst_lock",  32'(lock_status),  32'd0);
    chk("rst_deny",  32'(deny_count),   32'd0);
    repeat (2) @(posedge Clk);
    #2;
    resetn = 1'b1;
    cmp_en = 1'b1;

    // Unlocked read of entry 2.
    do_read(2'd2, 1'b0, 1'b0, 1'b0, dat, e);
    chk("e2_data", 32'(dat), 32'hA5A5);
    chk("e2_err",  32'(e),   32'd0);

    // Lock entry 1; trusted alone cannot bypass, trusted+debug can.
    Lock = 1'b1; lock_addr = 2'd1;
    @(posedge Clk); #2;
    Lock = 1'b0;
    chk("lock1_status", 32'(lock_status), 32'b0010);
    do_read(2'd1, 1'b1, 1'b0, 1'b0, dat, e);
    chk("deny1_data", 32'(dat), 32'h0);
    chk("deny1_err",  32'(e),   32'd1);
    chk("deny1_cnt",  32'(deny_count), 32'd1);
    do_read(2'd1, 1'b0, 1'b1, 1'b0, dat, e);
    chk("dbgonly_err", 32'(e), 32'd1);
    chk("dbgonly_cnt", 32'(deny_count), 32'd2);
    do_read(2'd1, 1'b1, 1'b1, 1'b0, dat, e);
    chk("bypass_data", 32'(dat), 32'h1234);
    chk("bypass_err",  32'(e),   32'd0);
    chk("bypass_cnt",  32'(deny_count), 32'd2);

    // Response held under backpressure while inputs churn.
    bus.rd_ready = 1'b0;
    do_read(2'd3, 1'b0, 1'b0, 1'b0, dat, e);
    held_dat = bus.Data_out;
    held_e = bus.rd_err;
    chk("hold_first", 32'(held_dat), 32'h3C3C);
    for (int i = 0; i < 5; i++) begin
      Reg_data = ~Reg_data;
      Lock = ~Lock;
      lock_addr = 2'd0;
      trusted = ~trusted;
      debug_mode = ~debug_mode;
      bus.rd_req = (i % 2 == 0);
      bus.rd_addr = 2'(i);
      @(posedge Clk); #1;
      chk("hold_valid", 32'(bus.rd_valid), 32'd1);
      chk("hold_data",  32'(bus.Data_out), 32'(held_dat));
      chk("hold_err",   32'(bus.rd_err),   32'(held_e));
      #1;
    end
    bus.rd_req = 1'b0;
    Lock = 1'b0;
    trusted = 1'b0;
    debug_mode = 1'b0;
    Reg_data = {16'h3C3C, 16'hA5A5, 16'h1234, 16'hBEEF};
    bus.rd_ready = 1'b1;
    @(posedge Clk); #1;
    chk("hold_release", 32'(bus.rd_valid), 32'd0);
    chk("retain_data",  32'(bus.Data_out), 32'h3C3C);
    #1;

    // Make sure entry 0 is locked, then saturate the denial counter.
    Lock = 1'b1; lock_addr = 2'd0;
    @(posedge Clk); #2;
    Lock = 1'b0;
    for (int i = 0; i < 300; i++) do_read(2'd0, 1'b0, 1'b0, 1'b0, dat, e);
    chk("sat_cnt", 32'(deny_count), 32'd255);
    chk("sat_err", 32'(e), 32'd1);

    // Lock raised during the fetch of entry 3 applies only afterwards.
    do_read(2'd3, 1'b0, 1'b0, 1'b1, dat, e);
    chk("lockfetch_data", 32'(dat), 32'h3C3C);
    chk("lockfetch_err",  32'(e),   32'd0);
    do_read(2'd3, 1'b0, 1'b0, 1'b0, dat, e);
    chk("lockafter_data", 32'(dat), 32'h0);
    chk("lockafter_err",  32'(e),   32'd1);
    chk("lockafter_cnt",  32'(deny_count), 32'd255);

    // Reset during RESP aborts immediately and clears locks.
    bus.rd_ready = 1'b0;
    do_read(2'd2, 1'b0, 1'b0, 1'b0, dat, e);
    @(posedge Clk); #1;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.rd_valid), 32'd0);
    chk("arst_busy",  32'(bus.rd_busy),  32'd0);
    chk("arst_lock",  32'(lock_status),  32'd0);
    chk("arst_deny",  32'(deny_count),   32'd0);
    chk("arst_data",  32'(bus.Data_out), 32'd0);
    bus.rd_ready = 1'b1;
    @(posedge Clk); #2;
    resetn = 1'b1;
    do_read(2'd3, 1'b0, 1'b0, 1'b0, dat, e);
    chk("postrst_data", 32'(dat), 32'h3C3C);
    chk("postrst_err",  32'(e),   32'd0);
    chk("postrst_cnt",  32'(deny_count), 32'd0);

    repeat (2) @(posedge Clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
